// File: rtl/breakout_pkg.sv
// Shared breakout types and screen geometry used by paddle_ctrl, mem_addr_gen and ball_control.
package breakout_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE_L = 2'd1,
    MOVE_R = 2'd2
  } paddle_dir_e;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int PADDLE_W = 80;
  localparam int PADDLE_Y = 467;

  // Both keys held, or neither, means stop.
  function automatic paddle_dir_e req_dir(input logic l, input logic r);
    paddle_dir_e d;
    d = IDLE;
    if (l && !r)
      d = MOVE_L;
    else if (r && !l)
      d = MOVE_R;
    return d;
  endfunction

endpackage

// File: rtl/paddle_ctrl_if.sv
// Paddle controller bus: tick strobe and held-key levels in, packed positions and status out.
interface paddle_ctrl_if #(
  parameter int NUM_PADDLES = 2,
  parameter int X_W         = 10
);

  logic                         tick;
  logic [NUM_PADDLES-1:0]       left_req;
  logic [NUM_PADDLES-1:0]       right_req;
  logic [NUM_PADDLES*X_W-1:0]   paddle_x;
  logic [NUM_PADDLES-1:0]       moving;
  logic [NUM_PADDLES-1:0]       at_edge;

  modport master (
    output tick, left_req, right_req,
    input  paddle_x, moving, at_edge
  );

  modport slave (
    input  tick, left_req, right_req,
    output paddle_x, moving, at_edge
  );

endinterface

// File: rtl/paddle_ctrl_axis.sv
// One paddle channel: direction FSM, accelerating step, X position (PADDLE_WRAP_EN wraps instead of clamping).
// Updates only on tick edges, new position visible the next cycle; no backpressure.
module paddle_axis
  import breakout_pkg::*;
#(
  parameter int X_W         = 10,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 560,
  parameter int X_INIT      = 280,
  parameter int STEP_MIN    = 2,
  parameter int STEP_MAX    = 8,
  parameter int ACCEL_TICKS = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick,
  input  logic           left_req,
  input  logic           right_req,
  output logic [X_W-1:0] x,
  output logic           moving,
  output logic           at_edge
);

  localparam int CNT_W = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;

  localparam logic [X_W:0]     XMIN_E   = (X_W+1)'(X_MIN);
  localparam logic [X_W:0]     XMAX_E   = (X_W+1)'(X_MAX);
  localparam logic [X_W:0]     SMIN_E   = (X_W+1)'(STEP_MIN);
  localparam logic [X_W:0]     SMAX_E   = (X_W+1)'(STEP_MAX);
  localparam logic [X_W:0]     ONE_E    = (X_W+1)'(1);
  localparam logic [CNT_W-1:0] ACC_LAST = CNT_W'(ACCEL_TICKS - 1);
  localparam logic [X_W-1:0]   XINIT_V  = X_W'(X_INIT);
  localparam logic             EDGE_INIT = (X_INIT == X_MIN) || (X_INIT == X_MAX);

  paddle_dir_e      state_q, state_n, req;
  logic [X_W:0]     step_q, step_n, step_use;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [X_W:0]     x_ext, sum, nx_ext;
  logic [X_W-1:0]   x_n;
  logic             moving_n;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      step_q  <= SMIN_E;
      cnt_q   <= '0;
      x       <= XINIT_V;
      moving  <= 1'b0;
      at_edge <= EDGE_INIT;
    end else if (tick) begin
      state_q <= state_n;
      step_q  <= step_n;
      cnt_q   <= cnt_n;
      x       <= x_n;
      moving  <= moving_n;
      at_edge <= (x_n == XMIN_E[X_W-1:0]) || (x_n == XMAX_E[X_W-1:0]);
    end
  end

  // The step bump is applied on the tick that finds the counter full, so every
  // speed level (including the first) lasts exactly ACCEL_TICKS moves.
  always_comb begin
    req      = req_dir(left_req, right_req);
    state_n  = state_q;
    step_n   = step_q;
    cnt_n    = cnt_q;
    step_use = step_q;
    if (req == IDLE) begin
      state_n = IDLE;
      step_n  = SMIN_E;
      cnt_n   = '0;
    end else if (req != state_q) begin
      state_n  = req;
      step_n   = SMIN_E;
      cnt_n    = '0;
      step_use = SMIN_E;
    end else if (cnt_q == ACC_LAST) begin
      cnt_n    = '0;
      step_use = (step_q >= SMAX_E) ? SMAX_E : step_q + ONE_E;
      step_n   = step_use;
    end else begin
      cnt_n = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    x_ext  = {1'b0, x};
    sum    = x_ext + step_use;
    nx_ext = x_ext;
    case (req)
      MOVE_R: begin
        if (sum > XMAX_E)
`ifdef PADDLE_WRAP_EN
          nx_ext = XMIN_E + (sum - XMAX_E - ONE_E);
`else
          nx_ext = XMAX_E;
`endif
        else
          nx_ext = sum;
      end
      MOVE_L: begin
        if (x_ext < XMIN_E + step_use)
`ifdef PADDLE_WRAP_EN
          nx_ext = XMAX_E - (XMIN_E + step_use - x_ext - ONE_E);
`else
          nx_ext = XMIN_E;
`endif
        else
          nx_ext = x_ext - step_use;
      end
      default: nx_ext = x_ext;
    endcase
    x_n = nx_ext[X_W-1:0];
`ifdef PADDLE_WRAP_EN
    moving_n = (req != IDLE) && (step_use != '0);
`else
    moving_n = (x_n != x);
`endif
  end

endmodule

// File: rtl/paddle_ctrl.sv
// Multi-channel paddle position controller: NUM_PADDLES independent paddle_axis channels, packed outputs.
// Updates on tick, visible the next cycle; no backpressure. PADDLE_WRAP_EN selects wrap-around at the limits.
module paddle_ctrl #(
  parameter int NUM_PADDLES = 2,
  parameter int X_W         = 10,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 560,
  parameter int X_INIT      = 280,
  parameter int STEP_MIN    = 2,
  parameter int STEP_MAX    = 8,
  parameter int ACCEL_TICKS = 4
) (
  input  logic          clk,
  input  logic          rst,
  paddle_ctrl_if.slave  bus
);

  logic [NUM_PADDLES*X_W-1:0] x_v;
  logic [NUM_PADDLES-1:0]     moving_v;
  logic [NUM_PADDLES-1:0]     edge_v;

  for (genvar g = 0; g < NUM_PADDLES; g++) begin : g_ch
    paddle_axis #(
      .X_W         (X_W),
      .X_MIN       (X_MIN),
      .X_MAX       (X_MAX),
      .X_INIT      (X_INIT),
      .STEP_MIN    (STEP_MIN),
      .STEP_MAX    (STEP_MAX),
      .ACCEL_TICKS (ACCEL_TICKS)
    ) u_axis (
      .clk       (clk),
      .rst       (rst),
      .tick      (bus.tick),
      .left_req  (bus.left_req[g]),
      .right_req (bus.right_req[g]),
      .x         (x_v[g*X_W +: X_W]),
      .moving    (moving_v[g]),
      .at_edge   (edge_v[g])
    );
  end

  assign bus.paddle_x = x_v;
  assign bus.moving   = moving_v;
  assign bus.at_edge  = edge_v;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Bench for paddle_ctrl: vector table for reset/acceleration, model-fed scoreboard for the longer sequences.
module tb_paddle_ctrl;

  localparam int NP    = 2;
  localparam int XW    = 10;
  localparam int XMIN  = 0;
  localparam int XMAX  = 560;
  localparam int XINIT = 280;
  localparam int SMIN  = 2;
  localparam int SMAX  = 8;
  localparam int ACC   = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  paddle_ctrl_if #(.NUM_PADDLES(NP), .X_W(XW)) bus ();

  paddle_ctrl #(
    .NUM_PADDLES(NP), .X_W(XW), .X_MIN(XMIN), .X_MAX(XMAX), .X_INIT(XINIT),
    .STEP_MIN(SMIN), .STEP_MAX(SMAX), .ACCEL_TICKS(ACC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [9:0] x1;
    logic [9:0] x0;
    logic [1:0] mv;
    logic [1:0] edg;
  } exp_t;

  typedef struct {
    logic [1:0] l;
    logic [1:0] r;
    logic       t;
    logic       rv;
    exp_t       e;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[15];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference state per channel: position, direction (0 none, 1 left, 2 right), run length, moving flag.
  int mx[2];
  int mdir[2];
  int mrun[2];
  int mmv[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int next_x(input int x, input int d, input int st);
    int s;
    int r;
    if (d == 2) begin
      s = x + st;
`ifdef PADDLE_WRAP_EN
      r = (s > XMAX) ? XMIN + (s - XMAX - 1) : s;
`else
      r = (s > XMAX) ? XMAX : s;
`endif
    end else begin
`ifdef PADDLE_WRAP_EN
      r = (x < XMIN + st) ? XMAX - (XMIN + st - x - 1) : x - st;
`else
      r = (x < XMIN + st) ? XMIN : x - st;
`endif
    end
    return r;
  endfunction

  function automatic exp_t model_step(input logic [1:0] l, input logic [1:0] r,
                                      input logic t, input logic rv);
    exp_t e;
    int   d, st, nx;
    for (int c = 0; c < 2; c++) begin
      if (!rv) begin
        mx[c] = XINIT; mdir[c] = 0; mrun[c] = 0; mmv[c] = 0;
      end else if (t) begin
        d = (l[c] && !r[c]) ? 1 : (r[c] && !l[c]) ? 2 : 0;
        if (d == 0) begin
          mdir[c] = 0; mrun[c] = 0; mmv[c] = 0;
        end else begin
          if (d != mdir[c]) begin
            mdir[c] = d;
            mrun[c] = 0;
          end
          st = SMIN + mrun[c] / ACC;
          if (st > SMAX) st = SMAX;
          nx = next_x(mx[c], d, st);
`ifdef PADDLE_WRAP_EN
          mmv[c] = (st > 0) ? 1 : 0;
`else
          mmv[c] = (nx != mx[c]) ? 1 : 0;
`endif
          mx[c] = nx;
          mrun[c]++;
        end
      end
    end
    e.x0     = 10'(mx[0]);
    e.x1     = 10'(mx[1]);
    e.mv     = {mmv[1][0], mmv[0][0]};
    e.edg[0] = (mx[0] == XMIN) || (mx[0] == XMAX);
    e.edg[1] = (mx[1] == XMIN) || (mx[1] == XMAX);
    return e;
  endfunction

  function automatic vec_t mk(input logic [1:0] l, input logic [1:0] r, input logic t,
                              input logic rv, input int x0, input int x1,
                              input logic [1:0] mv, input logic [1:0] edg);
    vec_t v;
    v.l = l; v.r = r; v.t = t; v.rv = rv;
    v.e.x0 = 10'(x0); v.e.x1 = 10'(x1); v.e.mv = mv; v.e.edg = edg;
    return v;
  endfunction

  task automatic apply(input logic [1:0] l, input logic [1:0] r, input logic t,
                       input logic rv, input exp_t e);
    exp_t want;
    @(negedge clk);
    bus.left_req  = l;
    bus.right_req = r;
    bus.tick      = t;
    rst           = rv;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    want = sbq.pop_front();
    chk("paddle_x0", bus.paddle_x[9:0], want.x0);
    chk("paddle_x1", bus.paddle_x[19:10], want.x1);
    chk("moving", bus.moving, want.mv);
    chk("at_edge", bus.at_edge, want.edg);
  endtask

  task automatic run(input logic [1:0] l, input logic [1:0] r, input logic t, input logic rv);
    apply(l, r, t, rv, model_step(l, r, t, rv));
  endtask

  initial begin
    int acc_x[12];
    acc_x = '{282, 284, 286, 288, 291, 294, 297, 300, 304, 308, 312, 316};
    bus.tick      = 1'b0;
    bus.left_req  = '0;
    bus.right_req = '0;

    // Reset with tick and keys active, release without tick, then 12 accelerating right ticks.
    tbl[0] = mk(2'b00, 2'b11, 1'b1, 1'b0, 280, 280, 2'b00, 2'b00);
    tbl[1] = mk(2'b00, 2'b11, 1'b1, 1'b0, 280, 280, 2'b00, 2'b00);
    tbl[2] = mk(2'b00, 2'b01, 1'b0, 1'b1, 280, 280, 2'b00, 2'b00);
    for (int i = 0; i < 12; i++)
      tbl[3+i] = mk(2'b00, 2'b01, 1'b1, 1'b1, acc_x[i], 280, 2'b01, 2'b00);
    for (int i = 0; i < 15; i++) begin
      void'(model_step(tbl[i].l, tbl[i].r, tbl[i].t, tbl[i].rv));
      apply(tbl[i].l, tbl[i].r, tbl[i].t, tbl[i].rv, tbl[i].e);
    end

    // Paddle 0 runs right toward X_MAX while paddle 1 runs left independently.
    for (int i = 0; i < 100 && mx[0] != 556; i++)
      run(2'b10, 2'b01, 1'b1, 1'b1);
    chk("pre_sat_x0", bus.paddle_x[9:0], 556);
    run(2'b10, 2'b01, 1'b1, 1'b1);
`ifdef PADDLE_WRAP_EN
    chk("wrap_x0_first", bus.paddle_x[9:0], 3);
`else
    chk("sat_x0_first", bus.paddle_x[9:0], 560);
`endif
    chk("sat_mv0_first", bus.moving[0], 1);
    run(2'b10, 2'b01, 1'b1, 1'b1);
`ifdef PADDLE_WRAP_EN
    chk("wrap_x0_second", bus.paddle_x[9:0], 11);
    chk("wrap_mv0_second", bus.moving[0], 1);
`else
    chk("sat_x0_second", bus.paddle_x[9:0], 560);
    chk("sat_mv0_second", bus.moving[0], 0);
    chk("sat_edge0_second", bus.at_edge[0], 1);
`endif
    for (int i = 0; i < 20; i++)
      run(2'b10, 2'b01, 1'b1, 1'b1);
`ifndef PADDLE_WRAP_EN
    chk("clamp_x1", bus.paddle_x[19:10], 0);
    chk("clamp_mv1", bus.moving[1], 0);
    chk("clamp_edge1", bus.at_edge[1], 1);
`endif
    run(2'b00, 2'b00, 1'b1, 1'b1);

    // Reset while moving, then build speed, conflict tick, reversal.
    run(2'b00, 2'b01, 1'b1, 1'b0);
    chk("midmove_reset_x0", bus.paddle_x[9:0], 280);
    for (int i = 0; i < 9; i++)
      run(2'b00, 2'b01, 1'b1, 1'b1);
    chk("pre_conflict_x0", bus.paddle_x[9:0], 304);
    run(2'b01, 2'b01, 1'b1, 1'b1);
    chk("conflict_x0", bus.paddle_x[9:0], 304);
    chk("conflict_mv0", bus.moving[0], 0);
    run(2'b01, 2'b00, 1'b1, 1'b1);
    chk("reverse_x0", bus.paddle_x[9:0], 302);
    chk("reverse_mv0", bus.moving[0], 1);

    // Keys held with tick low: nothing may change; one pulse gives exactly one update.
    for (int i = 0; i < 100; i++)
      run(2'b01, 2'b10, 1'b0, 1'b1);
    chk("gated_x0", bus.paddle_x[9:0], 302);
    run(2'b01, 2'b10, 1'b1, 1'b1);
    chk("pulse_x0", bus.paddle_x[9:0], 300);
    chk("pulse_x1", bus.paddle_x[19:10], 282);
    for (int i = 0; i < 5; i++)
      run(2'b01, 2'b10, 1'b0, 1'b1);

    @(negedge clk);
    bus.tick = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
